// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Single-outstanding instruction fetch controller with redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;
    localparam logic [31:0] c_reset_pc  = RESET_PC & c_word_mask;
    localparam logic [31:0] c_nop       = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_req_valid;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    logic        w_req_fire;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_next_seq;

    assign w_req_fire    = r_req_valid & imem_req_ready;
    assign w_redirect_pc = redirect_pc & c_word_mask;
    assign w_pc_next_seq = r_pc + 32'd4;

    // Outputs are registered; the request strobe stays low for the first
    // cycle after reset so the address is presented one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_REQ;
            r_pc          <= c_reset_pc;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= c_nop;
            r_instr_pc    <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_REQ: begin
                    r_req_valid <= 1'b1;
                    if (w_req_fire) begin
                        r_req_valid <= 1'b0;
                        if (redirect_valid) begin
                            // The accepted request targets the old pc.
                            r_pc    <= w_redirect_pc;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                end

                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (redirect_valid) begin
                            r_pc        <= w_redirect_pc;
                            r_req_valid <= 1'b1;
                            r_state     <= ST_REQ;
                        end else begin
                            r_instr       <= imem_rsp_data;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= ST_DRAIN;
                    end
                end

                ST_HOLD: begin
                    // Redirect takes priority over consumption.
                    if (redirect_valid) begin
                        r_pc          <= w_redirect_pc;
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_state       <= ST_REQ;
                    end else if (instr_ready) begin
                        r_pc          <= w_pc_next_seq;
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                        r_state       <= ST_REQ;
                    end
                end

                ST_DRAIN: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (imem_rsp_valid) begin
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end

                default: begin
                    r_req_valid   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= ST_REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;

endmodule

`default_nettype wire
